seven_segment_scanner: RTL and testbench

//   Display-side consumer of the 8-digit seven-segment bus (digit/en_digit/en_dot) produced by the

---
 rtl/seven_segment_scanner.sv | 101 ++++++++++
 tb/tb_seven_segment_scanner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 8-digit multiplexed seven-segment driver with blanking and per-scan snapshot
module seven_segment_scanner #(
  parameter int DIV        = 100000,
  parameter int BLANK      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digit,
  input  logic [7:0]  en_digit,
  input  logic [7:0]  en_dot,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int         CW       = $clog2(DIV);
  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_DRIVE = 1'b1;
  localparam logic       POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [31:0]   snap_digit, digit_nx;
  logic [7:0]    snap_en, en_nx;
  logic [7:0]    snap_dot, dot_nx;
  logic          first_load;
  logic          wrap, load, show;
  logic [0:0]    phase_nx;
  logic [3:0]    nib;
  logic [7:0]    an_on;
  logic [6:0]    seg_on;
  logic          dp_on;

  // Segment pattern with 1 = lit, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Outputs are derived from the next-state values so they line up with cnt/idx/snapshot
  always_comb begin
    wrap     = (cnt == CW'(DIV - 1));
    load     = first_load | (wrap & (idx == 3'd7));
    cnt_nx   = wrap ? '0 : cnt + 1'b1;
    idx_nx   = wrap ? idx + 3'd1 : idx;
    digit_nx = load ? digit    : snap_digit;
    en_nx    = load ? en_digit : snap_en;
    dot_nx   = load ? en_dot   : snap_dot;
    phase_nx = (int'(cnt_nx) < BLANK) ? PH_BLANK : PH_DRIVE;
    show     = (phase_nx == PH_DRIVE) && en_nx[idx_nx];
    nib      = digit_nx[{idx_nx, 2'b00} +: 4];
    an_on    = show ? (8'd1 << idx_nx) : 8'd0;
    seg_on   = show ? hex7(nib) : 7'd0;
    dp_on    = show & dot_nx[idx_nx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      snap_digit <= 32'd0;
      snap_en    <= 8'd0;
      snap_dot   <= 8'd0;
      first_load <= 1'b1;
      frame_tick <= 1'b0;
      an         <= {8{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      snap_digit <= digit_nx;
      snap_en    <= en_nx;
      snap_dot   <= dot_nx;
      first_load <= 1'b0;
      frame_tick <= load;
      an         <= an_on ^ {8{POL}};
      seg        <= seg_on ^ {7{POL}};
      dp         <= dp_on ^ POL;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - randomized self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digit = 32'h76543210;
  logic [7:0]  en_digit = 8'hFF;
  logic [7:0]  en_dot = 8'h00;

  logic [7:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       tick_a, tick_b, tick_c;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: k = clock edges since reset release, plus the captured snapshot
  int          k = 0;
  int          prev_tick_k = 0;
  logic [31:0] m_digit = 32'd0;
  logic [7:0]  m_en = 8'd0;
  logic [7:0]  m_dot = 8'd0;
  logic        m_tick = 1'b0;

  string hex_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  seven_segment_scanner #(.DIV(8), .BLANK(2), .ACTIVE_LOW(1)) u_a (
    .clk(clk), .rst(rst), .digit(digit), .en_digit(en_digit), .en_dot(en_dot),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(tick_a));

  seven_segment_scanner #(.DIV(8), .BLANK(0), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(rst), .digit(digit), .en_digit(en_digit), .en_dot(en_dot),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(tick_b));

  seven_segment_scanner #(.DIV(8), .BLANK(2), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .digit(digit), .en_digit(en_digit), .en_dot(en_dot),
    .an(an_c), .seg(seg_c), .dp(dp_c), .frame_tick(tick_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic logic [6:0] seg_bits(input int n);
    string s;
    logic [6:0] b;
    s = hex_segs[n];
    b = 7'd0;
    for (int j = 0; j < s.len(); j++) b[int'(s[j]) - 97] = 1'b1;
    return b;
  endfunction

  // Expected {an, seg, dp} after edge kk for a 64-clock scan of 8 slots of 8 clocks
  function automatic logic [15:0] exp_out(input int kk, input int blank, input bit al);
    int slot_pos, pos;
    bit lit;
    logic [7:0] a;
    logic [6:0] s;
    logic d;
    a = 8'd0; s = 7'd0; d = 1'b0;
    if (kk > 0) begin
      slot_pos = kk % 8;
      pos = (kk / 8) % 8;
      lit = (slot_pos >= blank) && m_en[pos];
      if (lit) begin
        a = 8'd1 << pos;
        s = seg_bits(int'((m_digit >> (4 * pos)) & 32'hF));
        d = m_dot[pos];
      end
    end
    if (al) return {~a, ~s, ~d};
    return {a, s, d};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      m_digit <= 32'd0;
      m_en <= 8'd0;
      m_dot <= 8'd0;
      m_tick <= 1'b0;
    end else begin
      k <= k + 1;
      if (k + 1 == 1 || (k + 1) % 64 == 0) begin
        m_digit <= digit;
        m_en <= en_digit;
        m_dot <= en_dot;
        m_tick <= 1'b1;
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ea, eb, ec;
    if (chk_en) begin
      ea = exp_out(k, 2, 1'b1);
      eb = exp_out(k, 0, 1'b1);
      ec = exp_out(k, 2, 1'b0);
      check("a_an", {24'd0, an_a}, {24'd0, ea[15:8]});
      check("a_seg", {25'd0, seg_a}, {25'd0, ea[7:1]});
      check("a_dp", {31'd0, dp_a}, {31'd0, ea[0]});
      check("a_tick", {31'd0, tick_a}, {31'd0, m_tick});
      check("b_an", {24'd0, an_b}, {24'd0, eb[15:8]});
      check("b_seg", {25'd0, seg_b}, {25'd0, eb[7:1]});
      check("b_dp", {31'd0, dp_b}, {31'd0, eb[0]});
      check("b_tick", {31'd0, tick_b}, {31'd0, m_tick});
      check("c_an", {24'd0, an_c}, {24'd0, ec[15:8]});
      check("c_seg", {25'd0, seg_c}, {25'd0, ec[7:1]});
      check("c_dp", {31'd0, dp_c}, {31'd0, ec[0]});
      check("c_tick", {31'd0, tick_c}, {31'd0, m_tick});
      if (tick_a) begin
        if (prev_tick_k > 1) check("tick_period", k - prev_tick_k, 64);
        prev_tick_k <= k;
      end
    end
    if (rst) prev_tick_k <= 0;
  end

  task automatic wait_scan_pos(input int target, input string tag);
    int n;
    n = 0;
    while ((k % 64) != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, k % 64, target);
  endtask

  initial begin
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", {24'd0, an_a}, 32'hFF);
    check("rst_seg", {25'd0, seg_a}, 32'h7F);
    check("rst_dp", {31'd0, dp_a}, 32'd1);
    check("rst_tick", {31'd0, tick_a}, 32'd0);
    check("rst_an_hi", {24'd0, an_c}, 32'h00);

    rst = 1'b0;
    repeat (140) @(negedge clk);

    digit = 32'hF0000000; en_digit = 8'b1000_0001; en_dot = 8'h00;
    repeat (128) @(negedge clk);

    digit = $urandom; en_digit = 8'hFB; en_dot = 8'h05;
    repeat (128) @(negedge clk);

    digit = 32'h11111111; en_digit = 8'hFF; en_dot = 8'h00;
    repeat (64) @(negedge clk);
    wait_scan_pos(27, "wait_slot3");
    digit = 32'h22222222;
    repeat (128) @(negedge clk);

    for (int it = 0; it < 8; it++) begin
      digit = $urandom;
      en_digit = 8'($urandom);
      en_dot = 8'($urandom);
      repeat ($urandom_range(20, 90)) @(negedge clk);
    end

    wait_scan_pos(43, "wait_slot5");
    #2 rst = 1'b1;
    #1;
    check("mid_rst_an", {24'd0, an_a}, 32'hFF);
    check("mid_rst_seg", {25'd0, seg_a}, 32'h7F);
    check("mid_rst_dp", {31'd0, dp_a}, 32'd1);
    check("mid_rst_an_hi", {24'd0, an_c}, 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    digit = $urandom; en_digit = 8'hFF; en_dot = 8'($urandom);
    repeat (150) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
